// File: rtl/sw_alloc.sv
// rtl/sw_alloc.sv - switch allocator: per-output round-robin arbitration with wormhole locking
//
// Shares each output port (N,S,E,W,U,D = 0..5) among the input ports. An idle
// output grants the first eligible requester at or after its round-robin
// pointer. It then stays locked to that input until the tail flit transfers.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid[i], req_out[i*P +: P] (one-hot output request), req_tail[i]
//   out_ready[o], out_faulty[o]
//   grant[i*P+o], out_sel[o*IDXW +: IDXW], out_busy[o], xfer[o] (combinational)
//   err_multi_hot[i] (sticky)
//   wd_err[o] (sticky, only with SW_ALLOC_WATCHDOG_EN)
//
// Optional feature macro: SW_ALLOC_WATCHDOG_EN. When it is defined, a lock that
// sees WD_CYCLES consecutive cycles without a transfer is force-released.

module sw_alloc #(
    parameter int NUM_PORTS = 6,
    parameter int IDXW      = $clog2(NUM_PORTS)
`ifdef SW_ALLOC_WATCHDOG_EN
    ,
    parameter int WD_CYCLES = 64
`endif
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_out,
    input  logic [NUM_PORTS-1:0]           req_tail,
    input  logic [NUM_PORTS-1:0]           out_ready,
    input  logic [NUM_PORTS-1:0]           out_faulty,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS*IDXW-1:0]      out_sel,
    output logic [NUM_PORTS-1:0]           out_busy,
    output logic [NUM_PORTS-1:0]           xfer,
    output logic [NUM_PORTS-1:0]           err_multi_hot
`ifdef SW_ALLOC_WATCHDOG_EN
    ,
    output logic [NUM_PORTS-1:0]           wd_err
`endif
);

    localparam int N = NUM_PORTS;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state   [N];
    logic [IDXW-1:0] owner   [N];
    logic [IDXW-1:0] rr_ptr  [N];
    logic [IDXW-1:0] winner  [N];
    logic [IDXW-1:0] rr_next [N];

    logic [N-1:0]   locked;
    logic [N-1:0]   in_locked;
    logic [N-1:0]   one_hot;
    logic [N-1:0]   found;
    logic [N-1:0]   tail_x;
    logic [N-1:0]   wd_fire;
    logic [N-1:0]   release_o;
    logic [N*N-1:0] elig;        // elig[o*N+i]: input i may win output o

    always_comb begin
        for (int o = 0; o < N; o++) begin
            locked[o] = (state[o] == LOCKED);
        end
    end

    assign out_busy = locked;

    // Grant matrix and crossbar select come straight from lock state and owner.
    always_comb begin
        grant   = '0;
        out_sel = '0;
        for (int o = 0; o < N; o++) begin
            out_sel[o*IDXW +: IDXW] = owner[o];
            if (locked[o]) begin
                grant[int'(owner[o])*N + o] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_locked[i] = |grant[i*N +: N];
            one_hot[i]   = $onehot(req_out[i*N +: N]);
        end
    end

    always_comb begin
        elig = '0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                elig[o*N + i] = req_valid[i] && one_hot[i] && req_out[i*N + o]
                                && !out_faulty[o] && !in_locked[i];
            end
        end
    end

    // Rotating search starting at rr_ptr; the first hit wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < N; o++) begin
            found[o]  = 1'b0;
            winner[o] = '0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(rr_ptr[o]) + k) % N;
                if (!found[o] && elig[o*N + idx]) begin
                    found[o]  = 1'b1;
                    winner[o] = idx[IDXW-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            xfer[o]    = locked[o] && req_valid[owner[o]] && out_ready[o];
            tail_x[o]  = xfer[o] && req_tail[owner[o]];
            rr_next[o] = (int'(owner[o]) == N - 1) ? '0 : owner[o] + IDXW'(1);
        end
    end

`ifdef SW_ALLOC_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt [N];

    always_comb begin
        for (int o = 0; o < N; o++) begin
            wd_fire[o] = locked[o] && !xfer[o] && (wd_cnt[o] == WDW'(WD_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_err <= '0;
            for (int o = 0; o < N; o++) begin
                wd_cnt[o] <= '0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (!locked[o] || xfer[o] || wd_fire[o]) begin
                    wd_cnt[o] <= '0;
                end else begin
                    wd_cnt[o] <= wd_cnt[o] + WDW'(1);
                end
                if (wd_fire[o]) begin
                    wd_err[o] <= 1'b1;
                end
            end
        end
    end
`else
    assign wd_fire = '0;
`endif

    assign release_o = tail_x | wd_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_multi_hot <= '0;
            for (int o = 0; o < N; o++) begin
                state[o]  <= IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                case (state[o])
                    IDLE: begin
                        if (found[o]) begin
                            state[o] <= LOCKED;
                            owner[o] <= winner[o];
                        end
                    end
                    LOCKED: begin
                        if (release_o[o]) begin
                            state[o]  <= IDLE;
                            rr_ptr[o] <= rr_next[o];
                        end
                    end
                    default: state[o] <= IDLE;
                endcase
            end
            // A locked input's flits are steered by the lock, so its request
            // vector is not checked for one-hotness.
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !one_hot[i] && !in_locked[i]) begin
                    err_multi_hot[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_alloc.sv
// tb/tb_sw_alloc.sv - directed self-checking bench for sw_alloc
module tb_sw_alloc;

    logic        clk;
    logic        reset;
    logic [5:0]  req_valid;
    logic [35:0] req_out;
    logic [5:0]  req_tail;
    logic [5:0]  out_ready;
    logic [5:0]  out_faulty;
    logic [35:0] grant;
    logic [17:0] out_sel;
    logic [5:0]  out_busy;
    logic [5:0]  xfer;
    logic [5:0]  err_multi_hot;
`ifdef SW_ALLOC_WATCHDOG_EN
    logic [5:0]  wd_err;
`endif

    int checks = 0;
    int errors = 0;

`ifdef SW_ALLOC_WATCHDOG_EN
    sw_alloc #(.WD_CYCLES(8)) dut (
`else
    sw_alloc dut (
`endif
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_out       (req_out),
        .req_tail      (req_tail),
        .out_ready     (out_ready),
        .out_faulty    (out_faulty),
        .grant         (grant),
        .out_sel       (out_sel),
        .out_busy      (out_busy),
        .xfer          (xfer),
        .err_multi_hot (err_multi_hot)
`ifdef SW_ALLOC_WATCHDOG_EN
        ,
        .wd_err        (wd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req_valid = '0; req_out = '0; req_tail = '0; out_ready = '1; out_faulty = '0;
        tick; tick;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL reset_grant: got %h expected %h", grant, 36'd0); end
        checks++; if (out_busy !== 6'd0) begin errors++; $display("FAIL reset_busy: got %b expected %b", out_busy, 6'd0); end
        checks++; if (out_sel !== 18'd0) begin errors++; $display("FAIL reset_sel: got %h expected %h", out_sel, 18'd0); end
        checks++; if (err_multi_hot !== 6'd0) begin errors++; $display("FAIL reset_err: got %b expected %b", err_multi_hot, 6'd0); end
        checks++; if (xfer !== 6'd0) begin errors++; $display("FAIL reset_xfer: got %b expected %b", xfer, 6'd0); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_single;
        req_out = '0;
        req_valid = 6'b000100; req_out[2*6 +: 6] = 6'b000001; req_tail = 6'b000100;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL single_latency: got %h expected %h", grant, 36'd0); end
        tick;
        checks++; if (grant !== (36'd1 << 12)) begin errors++; $display("FAIL single_grant: got %h expected %h", grant, 36'd1 << 12); end
        checks++; if (out_busy !== 6'b000001) begin errors++; $display("FAIL single_busy: got %b expected %b", out_busy, 6'b000001); end
        checks++; if (xfer !== 6'b000001) begin errors++; $display("FAIL single_xfer: got %b expected %b", xfer, 6'b000001); end
        checks++; if (out_sel[2:0] !== 3'd2) begin errors++; $display("FAIL single_sel: got %0d expected %0d", out_sel[2:0], 2); end
        tick;
        req_valid = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL single_release: got %h expected %h", grant, 36'd0); end
        checks++; if (out_busy !== 6'd0) begin errors++; $display("FAIL single_busy_clr: got %b expected %b", out_busy, 6'd0); end
        // rr_ptr[0] is now 3: input 4 must beat input 1
        req_out = '0;
        req_out[1*6 +: 6] = 6'b000001; req_out[4*6 +: 6] = 6'b000001;
        req_valid = 6'b010010; req_tail = 6'b010010;
        tick;
        checks++; if (grant !== (36'd1 << 24)) begin errors++; $display("FAIL single_rr_ptr: got %h expected %h", grant, 36'd1 << 24); end
        tick;
        req_valid = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL single_rr_release: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_contention;
        logic [35:0] exp_g [7];
        exp_g[0] = 36'd1 << 10; exp_g[1] = 36'd0;
        exp_g[2] = 36'd1 << 22; exp_g[3] = 36'd0;
        exp_g[4] = 36'd1 << 34; exp_g[5] = 36'd0;
        exp_g[6] = 36'd1 << 10;
        req_out = '0;
        req_out[1*6 +: 6] = 6'b010000; req_out[3*6 +: 6] = 6'b010000; req_out[5*6 +: 6] = 6'b010000;
        req_valid = 6'b101010; req_tail = 6'b101010;
        for (int k = 0; k < 7; k++) begin
            tick;
            checks++;
            if (grant !== exp_g[k]) begin errors++; $display("FAIL contention_step%0d: got %h expected %h", k, grant, exp_g[k]); end
        end
        tick;
        req_valid = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL contention_end: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_wormhole;
        logic [7:0]  rdy;
        logic [35:0] exp_g;
        logic        exp_x;
        logic [2:0]  exp_s;
        rdy = 8'b11110101;          // bit c-1 = out_ready[2] in cycle c
        req_out = '0;
        req_out[0*6 +: 6] = 6'b000100; req_out[1*6 +: 6] = 6'b000100;
        req_valid = 6'b000001; req_tail = 6'b000010;
        tick;
        for (int c = 1; c <= 8; c++) begin
            out_ready[2] = rdy[c-1];
            req_valid[0] = (c <= 6);
            req_tail[0]  = (c == 6);
            req_valid[1] = 1'b1;
            #1;
            exp_g = (c <= 6) ? (36'd1 << 2) : ((c == 7) ? 36'd0 : (36'd1 << 8));
            exp_x = (c == 7) ? 1'b0 : rdy[c-1];
            exp_s = (c == 8) ? 3'd1 : 3'd0;
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL wormhole_grant_c%0d: got %h expected %h", c, grant, exp_g); end
            checks++; if (xfer[2] !== exp_x) begin errors++; $display("FAIL wormhole_xfer_c%0d: got %b expected %b", c, xfer[2], exp_x); end
            checks++; if (out_sel[8:6] !== exp_s) begin errors++; $display("FAIL wormhole_sel_c%0d: got %0d expected %0d", c, out_sel[8:6], exp_s); end
            tick;
        end
        req_valid = '0; out_ready = '1;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL wormhole_end: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_fault;
        req_out = '0;
        out_faulty = 6'b010000;
        req_out[0 +: 6] = 6'b010000; req_valid = 6'b000001; req_tail = 6'b000000;
        for (int k = 0; k < 10; k++) begin
            tick;
            checks++; if (grant !== 36'd0) begin errors++; $display("FAIL fault_block_%0d: got %h expected %h", k, grant, 36'd0); end
        end
        out_faulty = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL fault_latency: got %h expected %h", grant, 36'd0); end
        tick;
        checks++; if (grant !== (36'd1 << 4)) begin errors++; $display("FAIL fault_grant: got %h expected %h", grant, 36'd1 << 4); end
        out_faulty = 6'b010000;
        tick;
        checks++; if (grant !== (36'd1 << 4)) begin errors++; $display("FAIL fault_midpkt_hold: got %h expected %h", grant, 36'd1 << 4); end
        checks++; if (xfer !== 6'b010000) begin errors++; $display("FAIL fault_midpkt_xfer: got %b expected %b", xfer, 6'b010000); end
        req_tail = 6'b000001;
        tick;
        req_valid = '0; out_faulty = '0; req_tail = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL fault_tail_release: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_simultaneous;
        req_out = '0;
        req_out[0 +: 6] = 6'b000001; req_valid = 6'b000001; req_tail = '0;
        tick;
        checks++; if (grant !== 36'd1) begin errors++; $display("FAIL simul_lock0: got %h expected %h", grant, 36'd1); end
        req_tail = 6'b000001;
        req_out[2*6 +: 6] = 6'b000010; req_valid = 6'b000101;
        tick;
        checks++; if (grant !== (36'd1 << 13)) begin errors++; $display("FAIL simul_release_grant: got %h expected %h", grant, 36'd1 << 13); end
        req_out[0 +: 6] = 6'b000100;
        tick;
        checks++; if (grant !== ((36'd1 << 13) | (36'd1 << 2))) begin errors++; $display("FAIL simul_regrant: got %h expected %h", grant, (36'd1 << 13) | (36'd1 << 2)); end
        req_tail = 6'b000101;
        tick;
        req_valid = '0; req_tail = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL simul_end: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_errors;
        req_out = '0;
        req_out[3*6 +: 6] = 6'b000011;
        req_valid = 6'b101000; req_tail = 6'b101000;
        #1;
        checks++; if (err_multi_hot !== 6'd0) begin errors++; $display("FAIL err_latency: got %b expected %b", err_multi_hot, 6'd0); end
        tick;
        checks++; if (err_multi_hot !== 6'b101000) begin errors++; $display("FAIL err_set: got %b expected %b", err_multi_hot, 6'b101000); end
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL err_no_grant: got %h expected %h", grant, 36'd0); end
        req_out[3*6 +: 6] = 6'b100000; req_valid = 6'b001000;
        tick;
        checks++; if (grant !== (36'd1 << 23)) begin errors++; $display("FAIL err_valid_grant: got %h expected %h", grant, 36'd1 << 23); end
        checks++; if (err_multi_hot !== 6'b101000) begin errors++; $display("FAIL err_sticky: got %b expected %b", err_multi_hot, 6'b101000); end
        tick;
        req_valid = '0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL err_end: got %h expected %h", grant, 36'd0); end
    endtask

    task automatic test_reset_mid;
        req_out = '0;
        req_out[0 +: 6] = 6'b000010; req_valid = 6'b000001; req_tail = '0;
        tick;
        checks++; if (grant !== (36'd1 << 1)) begin errors++; $display("FAIL rstmid_lock: got %h expected %h", grant, 36'd1 << 1); end
        reset = 1'b0;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL rstmid_grant: got %h expected %h", grant, 36'd0); end
        checks++; if (out_busy !== 6'd0) begin errors++; $display("FAIL rstmid_busy: got %b expected %b", out_busy, 6'd0); end
        checks++; if (err_multi_hot !== 6'd0) begin errors++; $display("FAIL rstmid_err: got %b expected %b", err_multi_hot, 6'd0); end
        tick;
        req_valid = '0; reset = 1'b1;
        tick;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL rstmid_after: got %h expected %h", grant, 36'd0); end
    endtask

`ifdef SW_ALLOC_WATCHDOG_EN
    task automatic test_watchdog;
        req_out = '0;
        req_out[0 +: 6] = 6'b000010; req_valid = 6'b000001; req_tail = '0;
        out_ready = 6'b111101;
        tick;
        checks++; if (grant !== (36'd1 << 1)) begin errors++; $display("FAIL wd_lock: got %h expected %h", grant, 36'd1 << 1); end
        for (int s = 1; s < 8; s++) begin
            tick;
            checks++; if (grant !== (36'd1 << 1)) begin errors++; $display("FAIL wd_hold_%0d: got %h expected %h", s, grant, 36'd1 << 1); end
        end
        checks++; if (wd_err !== 6'd0) begin errors++; $display("FAIL wd_err_early: got %b expected %b", wd_err, 6'd0); end
        tick;
        req_valid = '0; out_ready = '1;
        #1;
        checks++; if (grant !== 36'd0) begin errors++; $display("FAIL wd_release: got %h expected %h", grant, 36'd0); end
        checks++; if (wd_err !== 6'b000010) begin errors++; $display("FAIL wd_err_set: got %b expected %b", wd_err, 6'b000010); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_fault;
        test_simultaneous;
        test_wormhole;
        test_errors;
        test_reset_mid;
`ifdef SW_ALLOC_WATCHDOG_EN
        test_watchdog;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
